// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared FSM encoding and constants for the multiply/divide unit
package mult_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULT   = 2'd1,
    ST_DIV    = 2'd2,
    ST_FINISH = 2'd3
  } md_state_t;

  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] DIV_OVF    = 32'h8000_0000;

endpackage

// File: rtl/signed_mag_convert.sv
// rtl/signed_mag_convert.sv - two's-complement conditional negate (abs value when negate = sign bit)
module signed_mag_convert #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle signed multiply/divide with HI/LO registers
// Shift-add multiply and restoring divide share one 64-bit accumulator.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  localparam int CNT_W = $clog2(ITER_COUNT);

  md_state_t           state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opnd;
  logic                neg_res, neg_rem, is_div, dz;

  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [2*DATA_W-1:0] prod_fixed;
  logic [DATA_W-1:0]   quot_fixed, rem_fixed;
  logic [DATA_W:0]     mult_sum;
  logic [DATA_W+1:0]   div_diff;
  logic [2*DATA_W-1:0] mult_next, div_next;
  logic                last_step;

  signed_mag_convert #(.W(DATA_W)) u_abs_a (.value(op_a), .negate(op_a[DATA_W-1]), .result(mag_a));
  signed_mag_convert #(.W(DATA_W)) u_abs_b (.value(op_b), .negate(op_b[DATA_W-1]), .result(mag_b));
  signed_mag_convert #(.W(2*DATA_W)) u_fix_prod (.value(acc), .negate(neg_res), .result(prod_fixed));
  signed_mag_convert #(.W(DATA_W)) u_fix_quot (.value(acc[DATA_W-1:0]), .negate(neg_res), .result(quot_fixed));
  signed_mag_convert #(.W(DATA_W)) u_fix_rem (.value(acc[2*DATA_W-1:DATA_W]), .negate(neg_rem), .result(rem_fixed));

  // Multiply: upper half accumulates, multiplier shifts out of the lower half.
  assign mult_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
  assign mult_next = {mult_sum, acc[DATA_W-1:1]};

  // Divide: upper half is the partial remainder, quotient bits shift into the lower half.
  assign div_diff  = {1'b0, acc[2*DATA_W-1:DATA_W-1]} - {2'b00, opnd};
  assign div_next  = div_diff[DATA_W+1] ? {acc[2*DATA_W-2:0], 1'b0}
                                        : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

  assign last_step = (cnt == CNT_W'(ITER_COUNT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_mult)     next_state = ST_MULT;
        else if (start_div) next_state = (op_b == '0) ? ST_FINISH : ST_DIV;
      end
      ST_MULT, ST_DIV: if (last_step) next_state = ST_FINISH;
      ST_FINISH:       next_state = ST_IDLE;
      default:         next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      is_div   <= 1'b0;
      dz       <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_mult) begin
            opnd    <= mag_a;
            acc     <= {{DATA_W{1'b0}}, mag_b};
            neg_res <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
            is_div  <= 1'b0;
            dz      <= 1'b0;
            busy    <= 1'b1;
          end else if (start_div) begin
            opnd    <= mag_b;
            acc     <= {{DATA_W{1'b0}}, mag_a};
            neg_res <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
            neg_rem <= op_a[DATA_W-1];
            is_div  <= 1'b1;
            dz      <= (op_b == '0);
            busy    <= 1'b1;
          end
        end
        ST_MULT: begin
          acc <= mult_next;
          cnt <= cnt + 1'b1;
        end
        ST_DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
        end
        ST_FINISH: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= dz;
          if (!dz) begin
            if (is_div) begin
              hi_out <= rem_fixed;
              lo_out <= quot_fixed;
            end else begin
              hi_out <= prod_fixed[2*DATA_W-1:DATA_W];
              lo_out <= prod_fixed[DATA_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed scoreboard bench for mult_div_unit
module tb_mult_div_unit;
  import mult_div_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult, start_div;
  logic [31:0] op_a, op_b;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  mult_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .op_a(op_a), .op_b(op_b), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input logic dz, input int lat);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Leaves the caller at 1 time unit after the start edge.
  task automatic launch(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_a = a; op_b = b; start_mult = m; start_div = d;
    @(posedge clk);
    #1;
    start_mult = 1'b0; start_div = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int inject_at);
    exp_t e;
    int   cyc    = 0;
    int   busy_n = 0;
    bit   seen   = 0;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    if (busy) busy_n++;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == inject_at) begin
        start_div = 1'b1; op_a = $urandom; op_b = 32'd0;
      end else begin
        start_div = 1'b0;
      end
      if (done) seen = 1;
      else if (busy) busy_n++;
    end
    start_div = 1'b0;
    chk({tag, "_lat"},  64'(cyc),    64'(e.lat));
    chk({tag, "_busy"}, 64'(busy_n), 64'(e.lat));
    chk({tag, "_hi"},   64'(hi_out), 64'(e.hi));
    chk({tag, "_lo"},   64'(lo_out), 64'(e.lo));
    chk({tag, "_dz"},   64'(div_zero), 64'(e.dz));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 64'({done, div_zero}), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hilo",  {hi_out, lo_out}, 64'd0);
    chk("reset_flags", 64'({busy, done, div_zero}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    push(32'd0, 32'd42, 1'b0, 33);
    launch(1, 0, 32'd7, 32'd6);
    wait_result("mul_7x6", 0);

    push(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);
    launch(1, 0, 32'hFFFF_FFFD, 32'd5);
    wait_result("mul_m3x5", 0);

    push(32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33);
    launch(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_result("mul_max", 0);

    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    launch(0, 1, 32'hFFFF_FFF9, 32'd2);
    wait_result("div_m7_2", 0);

    push(32'd2, 32'hFFFF_FFF2, 1'b0, 33);
    launch(0, 1, 32'd100, 32'hFFFF_FFF9);
    wait_result("div_100_m7", 0);

    push(32'd0, DIV_OVF, 1'b0, 33);
    launch(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_ovf", 0);

    push(32'd0, 32'd42, 1'b0, 33);
    launch(1, 0, 32'd6, 32'd7);
    wait_result("mul_preload", 0);

    push(32'd0, 32'd42, 1'b1, 1);
    launch(0, 1, 32'd5, 32'd0);
    wait_result("div_zero", 0);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_hilo", {hi_out, lo_out}, {32'd0, 32'd42});

    push(32'd0, 32'd12, 1'b0, 33);
    launch(1, 0, 32'd3, 32'd4);
    wait_result("mul_ignore_start", 10);

    push(32'd0, 32'd27, 1'b0, 33);
    launch(1, 1, 32'd9, 32'd3);
    wait_result("both_starts", 0);

    launch(1, 0, 32'd123, 32'd456);
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_hilo",  {hi_out, lo_out}, 64'd0);
    chk("async_reset_flags", 64'({busy, done, div_zero}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    push(32'd0, 32'd4, 1'b0, 33);
    launch(1, 0, 32'd2, 32'd2);
    wait_result("mul_after_reset", 0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
